mulfx: RTL

Sequential two's-complement fixed-point multiplier with a start/done handshake, saturation and an overflow flag. It is the forward counterpart of the iterative fixed-point divider: same Q format, same operand conventions, same start-to-done latency style. It is used wherever the fluid solver scales velocities, densities or coefficients and a single-cycle WIDTH×WIDTH multiplier is too costly.

---
 rtl/fixed_pkg.sv | 9 +
 rtl/mulfx_mulu.sv | 37 +++
 rtl/mulfx.sv | 62 ++++++
 3 files changed

// File: rtl/fixed_pkg.sv
// fixed_pkg: shared Q-format defaults, FSM state type and sign/magnitude helper
package fixed_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_FBITS = 16;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic logic [DEF_WIDTH-1:0] mag(input logic [DEF_WIDTH-1:0] x);
    return x[DEF_WIDTH-1] ? -x : x;
  endfunction
endpackage

// File: rtl/mulfx_mulu.sv
// mulu: unsigned shift-add multiplier core, one multiplier bit per cycle, LSB first
module mulu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   am_i,
  input  logic [WIDTH-1:0]   bm_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               last_o
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] acc_q, mq_q, am_q;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    cnt_q;
  assign sum    = {1'b0, acc_q} + (mq_q[0] ? {1'b0, am_q} : '0);
  assign prod_o = {acc_q, mq_q};
  assign last_o = cnt_q == CW'(1);
  // load operands, then add-and-shift until the counter runs out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      mq_q  <= '0;
      am_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= '0;
      mq_q  <= bm_i;
      am_q  <= am_i;
      cnt_q <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      {acc_q, mq_q} <= {sum, mq_q[WIDTH-1:1]};
      cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/mulfx.sv
// mulfx: sequential saturating Q-format multiplier with start/done handshake
module mulfx
  import fixed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FBITS = DEF_FBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] p,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam logic [2*WIDTH-1:0] HALF = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  state_t             state_q, state_d;
  logic               sign_q, fin_q, ovf_q, ovf_d, take, last;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [2*WIDTH-1:0] prod, m;
  mulu #(.WIDTH(WIDTH)) u_mulu (
    .clk    (clk),
    .rst    (rst),
    .load_i (take),
    .am_i   (mag(a)),
    .bm_i   (mag(b)),
    .prod_o (prod),
    .last_o (last)
  );
  assign take = start && state_q != CALC;
  // next state plus truncated, saturated result of the finished product
  always_comb begin
    state_d = take ? CALC : state_q == CALC ? (fin_q ? DONE : CALC) : IDLE;
    m       = prod >> FBITS;
    ovf_d   = sign_q ? m > HALF : m >= HALF;
    p_d     = ovf_d ? {sign_q, {(WIDTH-1){~sign_q}}} : sign_q ? -m[WIDTH-1:0] : m[WIDTH-1:0];
  end
  // fin_q marks the cycle after the last iteration, when the product is final
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      fin_q   <= 1'b0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= state_q == CALC && last;
      if (take) sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
      if (fin_q) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
    end
  end
  assign p    = p_q;
  assign ovf  = ovf_q;
  assign busy = state_q == CALC && !fin_q;
  assign done = state_q == DONE;
endmodule
